// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Turns each address loaded into the PC register into one instruction-memory
// request, keeps fetches in order in a small buffer, and hands {pc, instr,
// fault} to decode over valid/ready. The PC register is throttled through
// pc_en_o so no more than DEPTH fetches are ever outstanding. A flush drops
// every buffered and in-flight fetch; responses still owed by memory for the
// dropped requests are swallowed by a drop counter.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   pc_valid_i, pc_i             freshly loaded PC (one-cycle pulse per load)
//   pc_en_o                      load enable for the PC register
//   flush_i                      redirect; PC register loads the target this cycle
//   imem_req_valid_o/ready_i/addr_o   fetch request
//   imem_rsp_valid_i/data_i/err_i     in-order fetch response (no ready)
//   dec_valid_o/ready_i/pc_o/instr_o/fault_o   decode handoff
module fetch_unit #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_valid_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_en_o,
    input  logic            flush_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [ILEN-1:0] dec_instr_o,
    output logic            dec_fault_o
);

    localparam int CW = $clog2(DEPTH + 1);   // inflight / drop counters
    localparam int PW = $clog2(DEPTH) + 1;   // buffer pointers incl. wrap bit
    localparam int IW = PW - 1;              // buffer index

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            err;
    } entry_t;

    entry_t [DEPTH-1:0] buf_q;

    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic [PW-1:0]   alloc_q, alloc_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic [PW-1:0]   pop_q, pop_d;

    logic req_fire, dec_fire, rsp_keep, pend_next;
    logic [IW-1:0] alloc_idx, fill_idx, pop_idx;

    assign alloc_idx = alloc_q[IW-1:0];
    assign fill_idx  = fill_q[IW-1:0];
    assign pop_idx   = pop_q[IW-1:0];

    assign imem_req_valid_o = pend_q;
    assign imem_req_addr_o  = pend_pc_q;
    assign req_fire         = pend_q && imem_req_ready_i;

    assign dec_valid_o = (pop_q != fill_q);
    assign dec_pc_o    = buf_q[pop_idx].pc;
    assign dec_instr_o = buf_q[pop_idx].instr;
    assign dec_fault_o = buf_q[pop_idx].err;

    // A handshake in the flush cycle is discarded along with everything else.
    assign dec_fire = dec_valid_o && dec_ready_i && !flush_i;

    // Responses owed to dropped requests arrive first; only keep once they
    // have all drained.
    assign rsp_keep = imem_rsp_valid_i && (drop_q == '0) && !flush_i;

    // Grant a load only if the pending slot will be free by the time the new
    // PC shows up next cycle. A flush always loads the redirect target.
    assign pend_next = (pend_q && !req_fire) || pc_valid_i;
    assign pc_en_o   = flush_i || (!rst_i && (inflight_q < CW'(DEPTH)) && !pend_next);

    always_comb begin
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        pop_d      = pop_q;
        drop_d     = drop_q;
        inflight_d = inflight_q;

        if (flush_i) begin
            // pc_valid_i here belongs to the old stream and is ignored.
            pend_d     = 1'b0;
            alloc_d    = '0;
            fill_d     = '0;
            pop_d      = '0;
            // Everything memory still owes us: unfilled allocations, plus the
            // request leaving now, minus the response arriving now.
            drop_d     = drop_q + CW'(alloc_q - fill_q) + CW'(req_fire)
                         - CW'(imem_rsp_valid_i);
            // The redirect load granted this cycle.
            inflight_d = CW'(1);
        end else begin
            if (pc_valid_i) begin
                pend_d    = 1'b1;
                pend_pc_d = pc_i;
            end else if (req_fire) begin
                pend_d = 1'b0;
            end
            if (req_fire) alloc_d = alloc_q + PW'(1);
            if (rsp_keep) fill_d  = fill_q + PW'(1);
            if (dec_fire) pop_d   = pop_q + PW'(1);
            if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
            inflight_d = inflight_q + CW'(pc_en_o) - CW'(dec_fire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            drop_q     <= '0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
            alloc_q    <= '0;
            fill_q     <= '0;
            pop_q      <= '0;
            buf_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            pop_q      <= pop_d;
            if (req_fire && !flush_i) buf_q[alloc_idx].pc <= pend_pc_q;
            if (rsp_keep) begin
                buf_q[fill_idx].instr <= imem_rsp_data_i;
                buf_q[fill_idx].err   <= imem_rsp_err_i;
            end
        end
    end

endmodule
